// File: rtl/fetch_pc_queue_if.sv
// Bundle between the fetch PC generator, the external predictor/writeback and decode.
// master = fetch_pc_queue side, slave = predictor/decode/writeback side.
interface fetch_pc_queue_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [1:0]      pred_kind;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    // Valid/ready: an entry transfers on the rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready and out_* hold until that edge.
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_next_pc;

    modport master (
        output fetch_pc, out_valid, out_pc, out_next_pc,
        input  pred_taken, pred_target, pred_kind, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  fetch_pc, out_valid, out_pc, out_next_pc,
        output pred_taken, pred_target, pred_kind, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_pc_queue.sv
// Fetch PC generator: picks the next PC from redirect, predictor hints and a return
// address stack, and buffers {pc, next pc} pairs in a queue drained by decode.
module fetch_pc_queue #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4,
    parameter int              Q_DEPTH      = 4,
    localparam int             RAS_CW       = $clog2(RAS_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    fetch_pc_queue_if.master    bus,
    output logic [RAS_CW-1:0]   ras_count_o
);
    localparam int RAS_AW = $clog2(RAS_DEPTH);
    localparam int Q_AW   = $clog2(Q_DEPTH);
    localparam int Q_CW   = Q_AW + 1;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   ras_mem_q [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_top_q;
    logic [RAS_CW-1:0] ras_count_q;
    logic [XLEN-1:0]   q_pc_q  [Q_DEPTH];
    logic [XLEN-1:0]   q_npc_q [Q_DEPTH];
    logic [Q_AW-1:0]   q_head_q, q_tail_q;
    logic [Q_CW-1:0]   q_count_q;

    logic [XLEN-1:0]   pc_plus4;
    logic [RAS_AW-1:0] ras_top_inc;
    logic              ras_empty, ras_full;
    logic              enq, deq, ras_push, ras_pop;

    always_comb begin
        pc_plus4    = fetch_pc_q + XLEN'(4);
        ras_top_inc = ras_top_q + RAS_AW'(1);
        ras_empty   = (ras_count_q == '0);
        ras_full    = (ras_count_q == RAS_CW'(RAS_DEPTH));
        enq         = !bus.redirect_valid && (q_count_q < Q_CW'(Q_DEPTH));
        deq         = (q_count_q != '0) && bus.out_ready;
        fetch_pc_d  = pc_plus4;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        case (bus.pred_kind)
            2'b11: begin
                if (!ras_empty) begin
                    fetch_pc_d = ras_mem_q[ras_top_q];
                    ras_pop    = enq;
                end else if (bus.pred_taken) begin
                    fetch_pc_d = bus.pred_target;
                end
            end
            2'b10: begin
                ras_push = enq;
                if (bus.pred_taken) fetch_pc_d = bus.pred_target;
            end
            2'b01: begin
                if (bus.pred_taken) fetch_pc_d = bus.pred_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_VECTOR;
            ras_top_q   <= '0;
            ras_count_q <= '0;
            q_head_q    <= '0;
            q_tail_q    <= '0;
            q_count_q   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_pc_q[i]  <= '0;
                q_npc_q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // A redirect discards everything speculative, including a same-cycle dequeue.
            fetch_pc_q  <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            ras_count_q <= '0;
            q_head_q    <= '0;
            q_tail_q    <= '0;
            q_count_q   <= '0;
        end else begin
            if (enq) begin
                q_pc_q[q_tail_q]  <= fetch_pc_q;
                q_npc_q[q_tail_q] <= fetch_pc_d;
                q_tail_q          <= q_tail_q + Q_AW'(1);
                fetch_pc_q        <= fetch_pc_d;
            end
            if (deq) q_head_q <= q_head_q + Q_AW'(1);
            if (enq && !deq)      q_count_q <= q_count_q + Q_CW'(1);
            else if (!enq && deq) q_count_q <= q_count_q - Q_CW'(1);
            // Pushing onto a full stack lands on the oldest slot, so it is simply overwritten.
            if (ras_push) begin
                ras_mem_q[ras_top_inc] <= pc_plus4;
                ras_top_q              <= ras_top_inc;
                if (!ras_full) ras_count_q <= ras_count_q + RAS_CW'(1);
            end else if (ras_pop) begin
                ras_top_q   <= ras_top_q - RAS_AW'(1);
                ras_count_q <= ras_count_q - RAS_CW'(1);
            end
        end
    end

    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.out_valid   = (q_count_q != '0);
    assign bus.out_pc      = q_pc_q[q_head_q];
    assign bus.out_next_pc = q_npc_q[q_head_q];
    assign ras_count_o     = ras_count_q;
endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: directed scenarios plus random traffic, checked against a
// queue-based reference model through a scoreboard.
module tb_fetch_pc_queue;
    localparam int          XLEN   = 32;
    localparam logic [31:0] RV     = 32'h100;
    localparam int          RAS_D  = 4;
    localparam int          Q_D    = 4;
    localparam int          RAS_CW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [RAS_CW-1:0] ras_count;
    always #5 clk = ~clk;

    fetch_pc_queue_if #(.XLEN(XLEN)) bus ();

    fetch_pc_queue #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(RAS_D), .Q_DEPTH(Q_D)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .ras_count_o(ras_count)
    );

    logic [63:0] exp_q[$];
    logic [31:0] ras_m[$];
    logic [31:0] mpc;
    int          deq_pending;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC and stack as plain values/queues, updated once per edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            ras_m.delete();
            mpc = RV;
            deq_pending = 0;
        end else begin
            int cnt;
            logic [31:0] nxt;
            cnt = exp_q.size() + deq_pending;
            deq_pending = 0;
            if (bus.redirect_valid) begin
                exp_q.delete();
                ras_m.delete();
                mpc = {bus.redirect_pc[31:2], 2'b00};
            end else if (cnt < Q_D) begin
                nxt = mpc + 32'd4;
                if (bus.pred_kind == 2'b11 && ras_m.size() > 0) begin
                    nxt = ras_m.pop_back();
                end else if (bus.pred_kind == 2'b10) begin
                    ras_m.push_back(mpc + 32'd4);
                    if (ras_m.size() > RAS_D) void'(ras_m.pop_front());
                    if (bus.pred_taken) nxt = bus.pred_target;
                end else if (bus.pred_kind != 2'b00 && bus.pred_taken) begin
                    nxt = bus.pred_target;
                end
                exp_q.push_back({mpc, nxt});
                mpc = nxt;
            end
        end
    end

    // Monitor: sampled mid-cycle, pops the scoreboard on every accepted head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("fetch_pc", bus.fetch_pc, mpc);
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            chk("ras_count", ras_count, ras_m.size());
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("out_pc", bus.out_pc, e[63:32]);
                    chk("out_next_pc", bus.out_next_pc, e[31:0]);
                    deq_pending = 1;
                end
            end
        end
    end

    task automatic drive(input logic [1:0] k, input logic t, input logic [31:0] tgt,
                         input logic rv, input logic [31:0] rp, input logic rdy);
        bus.pred_kind      = k;
        bus.pred_taken     = t;
        bus.pred_target    = tgt;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.pred_kind = 2'b00; bus.pred_taken = 1'b0; bus.pred_target = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        #12;
        chk("rst_fetch_pc", bus.fetch_pc, RV);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_next_pc", bus.out_next_pc, 0);
        chk("rst_ras_count", ras_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-pressure: queue fills with 0x100..0x10C, fetch_pc freezes at 0x110.
        repeat (6) drive(2'b00, 0, 0, 0, 0, 0);
        chk("full_fetch_pc", bus.fetch_pc, 32'h110);
        chk("full_head", bus.out_pc, 32'h100);
        repeat (8) drive(2'b00, 0, 0, 0, 0, 1);

        // Call at 0x200 to 0x800, then return at 0x804.
        drive(2'b00, 0, 0, 1, 32'h200, 1);
        drive(2'b10, 1, 32'h800, 0, 0, 1);
        chk("call_ras", ras_count, 1);
        chk("call_pc", bus.fetch_pc, 32'h800);
        drive(2'b00, 0, 0, 0, 0, 1);
        drive(2'b11, 1, 32'hDEAD0000, 0, 0, 1);
        chk("ret_pc", bus.fetch_pc, 32'h204);
        chk("ret_ras", ras_count, 0);

        // Five nested calls saturate the stack; five returns, last one falls through.
        drive(2'b00, 0, 0, 1, 32'h1000, 1);
        for (int i = 0; i < 5; i++) drive(2'b10, 1, 32'h2000 + i * 32'h100, 0, 0, 1);
        chk("nest_ras", ras_count, 4);
        for (int i = 0; i < 4; i++) drive(2'b11, 0, 32'h5550000, 0, 0, 1);
        chk("nest_pop4", bus.fetch_pc, 32'h2004);
        drive(2'b11, 0, 32'h5550000, 0, 0, 1);
        chk("nest_pop5", bus.fetch_pc, 32'h2008);

        // Redirect to 0x403 while three entries are queued.
        drive(2'b00, 0, 0, 1, 32'h300, 0);
        repeat (3) drive(2'b00, 0, 0, 0, 0, 0);
        drive(2'b10, 1, 32'h900, 1, 32'h403, 1);
        chk("redir_valid", bus.out_valid, 0);
        chk("redir_pc", bus.fetch_pc, 32'h400);
        chk("redir_ras", ras_count, 0);
        repeat (2) drive(2'b00, 0, 0, 0, 0, 1);

        // PC wrap.
        drive(2'b00, 0, 0, 1, 32'hFFFFFFFC, 1);
        drive(2'b00, 0, 0, 0, 0, 1);
        chk("wrap_pc", bus.fetch_pc, 32'h0);

        // Reset in the middle of traffic.
        drive(2'b10, 1, 32'h40, 0, 0, 0);
        drive(2'b00, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_pc", bus.fetch_pc, RV);
        chk("mid_rst_ras", ras_count, 0);
        rst = 1'b0;

        repeat (500) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFC) : $urandom;
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), tgt,
                  ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end
        repeat (6) drive(2'b00, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
